// File: rtl/ps2_pkg.sv
// ps2_pkg: shared PS/2 host types, command codes and memory-map constants
package ps2_pkg;
  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    RTS,
    SEND,
    ACK,
    WAIT_IDLE
  } ps2_tx_state_t;
  localparam logic [7:0] PS2_CMD_SET_LED = 8'hED;
  localparam logic [7:0] PS2_CMD_RESET = 8'hFF;
  localparam logic [7:0] PS2_RESP_ACK = 8'hFA;
  localparam logic [7:0] PS2_RESP_RESEND = 8'hFE;
  localparam logic [31:0] KBD_CMD = 32'hFFFF_0010;
endpackage

// File: rtl/ps2_line_sync.sv
// ps2_line_sync: two-flop synchronizer with falling-edge detect for one PS/2 line
module ps2_line_sync (
  input  logic clk,
  input  logic resetn,
  input  logic line_in,
  output logic line,
  output logic fall
);
  logic s0, s1, prev;
  always_ff @(posedge clk)
    if (!resetn) {s0, s1, prev} <= 3'b111;
    else {s0, s1, prev} <= {line_in, s0, s1};
  assign line = s1;
  assign fall = prev & ~s1;
endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 command transmitter with ACK check and timeout
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned INHIBIT_CYC = 5000,
  parameter int unsigned TIMEOUT_CYC = 750000
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       tx_err,
  output logic       busy,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);
  localparam int INH_W = $clog2(INHIBIT_CYC);
  localparam int TIM_W = $clog2(TIMEOUT_CYC);
  ps2_tx_state_t state, nxt;
  logic [9:0] frame;
  logic [3:0] bit_cnt;
  logic [INH_W-1:0] inh_cnt;
  logic [TIM_W-1:0] timer;
  logic data_q, clk_s, clk_fall, data_s, data_fall;
  logic inh_last, timed, timeout, ack_bad, idle_ok;
  ps2_line_sync u_clk_sync (
    .clk(clk), .resetn(resetn), .line_in(ps2_clk_in), .line(clk_s), .fall(clk_fall)
  );
  ps2_line_sync u_data_sync (
    .clk(clk), .resetn(resetn), .line_in(ps2_data_in), .line(data_s), .fall(data_fall)
  );
  assign inh_last = state == INHIBIT && inh_cnt == INH_W'(INHIBIT_CYC - 1);
  assign timed = state inside {SEND, ACK, WAIT_IDLE};
  assign timeout = timed && timer == TIM_W'(TIMEOUT_CYC - 1);
  assign ack_bad = state == ACK && clk_fall && data_s;
  assign idle_ok = state == WAIT_IDLE && clk_s && data_s;
  always_ff @(posedge clk)
    if (!resetn) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:      nxt = tx_valid ? INHIBIT : IDLE;
      INHIBIT:   nxt = inh_last ? RTS : INHIBIT;
      RTS:       nxt = SEND;
      SEND:      nxt = (clk_fall && bit_cnt == 4'd9) ? ACK : SEND;
      ACK:       nxt = clk_fall ? (data_s ? IDLE : WAIT_IDLE) : ACK;
      WAIT_IDLE: nxt = idle_ok ? IDLE : WAIT_IDLE;
      default:   nxt = IDLE;
    endcase
    if (timeout) nxt = IDLE;
  end
  always_comb begin
    tx_ready = state == IDLE;
    busy = state != IDLE;
    ps2_clk_oe = state == INHIBIT;
    ps2_data_oe = inh_last || state == RTS || (state == SEND && data_q);
  end
  always_ff @(posedge clk)
    if (!resetn) begin
      frame <= '0;
      bit_cnt <= '0;
      inh_cnt <= '0;
      timer <= '0;
      data_q <= 1'b0;
      tx_done <= 1'b0;
      tx_err <= 1'b0;
    end else begin
      tx_done <= idle_ok && !timeout;
      tx_err <= timeout || ack_bad;
      inh_cnt <= state == INHIBIT ? inh_cnt + 1'b1 : '0;
      timer <= (timed && !clk_fall) ? timer + 1'b1 : '0;
      if (state == IDLE && tx_valid) begin
        frame <= {1'b1, ~^tx_data, tx_data};
        bit_cnt <= '0;
      end
      if (state == RTS) data_q <= 1'b1;
      else if (state == SEND && clk_fall) begin
        data_q <= ~frame[bit_cnt];
        bit_cnt <= bit_cnt + 1'b1;
      end else if (state == IDLE) data_q <= 1'b0;
    end
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: scoreboard bench with a PS/2 device model for ps2_host_tx
module tb_ps2_host_tx;
  logic clk = 1'b0;
  logic resetn;
  logic [7:0] tx_data;
  logic tx_valid;
  logic tx_ready, tx_done, tx_err, busy;
  logic ps2_clk_in, ps2_data_in, ps2_clk_oe, ps2_data_oe;
  logic dev_clk = 1'b1;
  logic dev_data = 1'b1;
  int fall_n = 0;
  int nchk = 0;
  int nbad = 0;
  int exp_bits[$];
  int exp_ev[$];
  always #5 clk = ~clk;
  assign ps2_clk_in = ~ps2_clk_oe & dev_clk;
  assign ps2_data_in = ~ps2_data_oe & dev_data;
  ps2_host_tx #(.INHIBIT_CYC(20), .TIMEOUT_CYC(400)) dut (
    .clk(clk), .resetn(resetn), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .tx_done(tx_done), .tx_err(tx_err), .busy(busy),
    .ps2_clk_in(ps2_clk_in), .ps2_data_in(ps2_data_in),
    .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe)
  );
  task automatic chk(input string nm, input int act, input int exp);
    nchk++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s got=%0d want=%0d", nm, act, exp);
    end
  endtask
  always @(negedge clk)
    if (tx_done || tx_err) begin
      if (exp_ev.size() == 0) chk("unexpected_pulse", int'({tx_done, tx_err}), 0);
      else chk("event", int'({tx_done, tx_err}), exp_ev.pop_front());
    end
  always @(posedge dev_clk)
    if (fall_n >= 1 && fall_n <= 10) begin
      if (exp_bits.size() == 0) chk("extra_bit", fall_n, 0);
      else chk($sformatf("line_after_fall%0d", fall_n), int'(ps2_data_in), exp_bits.pop_front());
    end
  task automatic push_bits(input logic [9:0] p, input int n);
    for (int i = 0; i < n; i++) exp_bits.push_back(int'(p[i]));
  endtask
  task automatic start(input logic [7:0] b);
    @(negedge clk);
    tx_data = b;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    chk("busy_after_accept", int'(busy), 1);
  endtask
  task automatic inhibit_check(input string tag);
    int cnt = 0;
    int first = 0;
    while (ps2_clk_oe && cnt < 100) begin
      cnt++;
      if (ps2_data_oe && first == 0) first = cnt;
      @(negedge clk);
    end
    chk({tag, "_inhibit_len"}, cnt, 20);
    chk({tag, "_start_bit_at"}, first, 20);
  endtask
  task automatic device(input int nf, input bit ack);
    int n = 0;
    while (!(!ps2_clk_oe && ps2_data_oe) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("rts_seen", int'(n < 200), 1);
    fall_n = 0;
    for (int i = 1; i <= nf; i++) begin
      repeat (20) @(negedge clk);
      if (i == 11) dev_data = ~ack;
      fall_n = i;
      dev_clk = 1'b0;
      repeat (20) @(negedge clk);
      dev_clk = 1'b1;
    end
    dev_data = 1'b1;
  endtask
  task automatic frame_ok(input logic [7:0] b, input logic [9:0] line_bits, input string tag);
    push_bits(line_bits, 10);
    exp_ev.push_back(2);
    start(b);
    inhibit_check(tag);
    device(11, 1'b1);
    repeat (10) @(negedge clk);
    chk({tag, "_ready_after"}, int'(tx_ready), 1);
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    int n;
    resetn = 1'b0;
    tx_valid = 1'b0;
    tx_data = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_ready", int'(tx_ready), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_clk_oe", int'(ps2_clk_oe), 0);
    chk("rst_data_oe", int'(ps2_data_oe), 0);
    chk("rst_pulses", int'({tx_done, tx_err}), 0);
    resetn = 1'b1;
    repeat (3) @(negedge clk);
    frame_ok(8'hED, 10'h3ED, "ed");
    frame_ok(8'h00, 10'h300, "x00");
    frame_ok(8'h01, 10'h201, "x01");
    frame_ok(8'hFF, 10'h3FF, "xff");
    push_bits(10'h3ED, 10);
    exp_ev.push_back(1);
    start(8'hED);
    inhibit_check("nack");
    device(11, 1'b0);
    repeat (10) @(negedge clk);
    chk("nack_ready", int'(tx_ready), 1);
    exp_ev.push_back(1);
    start(8'hFF);
    inhibit_check("silent");
    n = 0;
    while (!tx_err && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("silent_timeout_cycles", n, 401);
    chk("silent_clk_oe", int'(ps2_clk_oe), 0);
    chk("silent_data_oe", int'(ps2_data_oe), 0);
    chk("silent_ready", int'(tx_ready), 1);
    push_bits(10'h201, 4);
    start(8'h01);
    inhibit_check("rstmid");
    device(4, 1'b1);
    @(negedge clk);
    chk("rstmid_pre_data_oe", int'(ps2_data_oe), 1);
    resetn = 1'b0;
    @(negedge clk);
    chk("rstmid_clk_oe", int'(ps2_clk_oe), 0);
    chk("rstmid_data_oe", int'(ps2_data_oe), 0);
    chk("rstmid_ready", int'(tx_ready), 1);
    resetn = 1'b1;
    repeat (3) @(negedge clk);
    frame_ok(8'hFF, 10'h3FF, "after_rst");
    push_bits(10'h3ED, 10);
    exp_ev.push_back(2);
    push_bits(10'h311, 10);
    exp_ev.push_back(2);
    @(negedge clk);
    tx_data = 8'hED;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_data = 8'h11;
    chk("b2b_busy", int'(busy), 1);
    inhibit_check("b2b_a");
    device(11, 1'b1);
    n = 0;
    while (!tx_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("b2b_ready_seen", int'(n < 200), 1);
    @(negedge clk);
    chk("b2b_readmit", int'(tx_ready), 0);
    tx_valid = 1'b0;
    inhibit_check("b2b_b");
    device(11, 1'b1);
    repeat (30) @(negedge clk);
    chk("ev_queue_left", exp_ev.size(), 0);
    chk("bit_queue_left", exp_bits.size(), 0);
    $display("test done: total=%0d bad=%0d", nchk, nbad);
    $finish;
  end
endmodule
